// File: rtl/mem_arbiter.sv
// Two-port arbiter in front of the unified instruction/data memory: serialises
// CPU and loader accesses, round-robin on ties, and hides the fixed read latency.
module mem_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int RD_LAT = 2
) (
  input  logic              clk_100M,
  input  logic              rst_n,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_ack,
  output logic [DATA_W-1:0] cpu_rdata,
  input  logic              dbg_req,
  input  logic              dbg_we,
  input  logic [ADDR_W-1:0] dbg_addr,
  input  logic [DATA_W-1:0] dbg_wdata,
  output logic              dbg_ack,
  output logic [DATA_W-1:0] dbg_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy,
  output logic              owner
);
  localparam int CNT_W = $clog2(RD_LAT + 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_WAIT  = 2'd2;
  localparam logic [1:0] S_RESP  = 2'd3;

  typedef struct packed {
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
  } req_t;

  logic [1:0]        state;
  logic [CNT_W-1:0]  cnt;
  logic              own;
  logic              last_owner;
  req_t              req_q;
  req_t              req_sel;
  logic [DATA_W-1:0] cpu_rdata_q;
  logic [DATA_W-1:0] dbg_rdata_q;
  logic              any_req;
  logic              pick_dbg;

  // On a tie the port that did not own the last transaction wins.
  assign any_req  = cpu_req | dbg_req;
  assign pick_dbg = dbg_req & (~cpu_req | ~last_owner);

  always_comb begin
    req_sel = pick_dbg ? {dbg_we, dbg_addr, dbg_wdata}
                       : {cpu_we, cpu_addr, cpu_wdata};
  end

  always_ff @(posedge clk_100M or negedge rst_n) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      cnt         <= '0;
      own         <= 1'b0;
      last_owner  <= 1'b1;
      req_q       <= '0;
      cpu_rdata_q <= '0;
      dbg_rdata_q <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (any_req) begin
            own   <= pick_dbg;
            req_q <= req_sel;
            state <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          if (req_q.we) begin
            state <= S_RESP;
          end else begin
            cnt   <= CNT_W'(RD_LAT - 1);
            state <= S_WAIT;
          end
        end
        S_WAIT: begin
          // cnt reaches zero in the cycle ISSUE+RD_LAT, when read data is valid
          if (cnt == '0) begin
            if (own) dbg_rdata_q <= mem_rdata;
            else     cpu_rdata_q <= mem_rdata;
            state <= S_RESP;
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end
        S_RESP: begin
          last_owner <= own;
          state      <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign mem_en    = (state == S_ISSUE);
  assign mem_we    = (state == S_ISSUE) & req_q.we;
  assign mem_addr  = req_q.addr;
  assign mem_wdata = req_q.wdata;
  assign busy      = (state != S_IDLE);
  assign owner     = own;
  assign cpu_ack   = (state == S_RESP) & ~own;
  assign dbg_ack   = (state == S_RESP) & own;
  assign cpu_rdata = cpu_rdata_q;
  assign dbg_rdata = dbg_rdata_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: three instances (RD_LAT 2, 1, 7) each with a latency
// memory model; expected transactions queued at issue and checked at ack.
module tb_mem_arbiter;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int NI = 3;

  function automatic int lat_of(input int g);
    return (g == 0) ? 2 : (g == 1) ? 1 : 7;
  endfunction

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic          cpu_req [NI], cpu_we [NI], dbg_req [NI], dbg_we [NI];
  logic [AW-1:0] cpu_addr [NI], dbg_addr [NI], mem_addr [NI];
  logic [DW-1:0] cpu_wdata [NI], dbg_wdata [NI], cpu_rdata [NI], dbg_rdata [NI];
  logic [DW-1:0] mem_wdata [NI], mem_rdata [NI];
  logic          cpu_ack [NI], dbg_ack [NI], mem_en [NI], mem_we [NI];
  logic          busy [NI], owner [NI];

  for (genvar g = 0; g < NI; g++) begin : g_dut
    localparam int L = (g == 0) ? 2 : (g == 1) ? 1 : 7;
    logic [DW-1:0] mem [256];
    logic [DW-1:0] pd [L];
    logic          pv [L];

    initial begin
      for (int i = 0; i < 256; i++) mem[i] = {16'hC0DE, 16'(i * 4)};
      mem[16] = 32'hDEAD_BEEF;
      for (int i = 0; i < L; i++) pv[i] = 1'b0;
    end

    // Read data appears exactly L cycles after mem_en; garbage otherwise.
    always @(posedge clk) begin
      if (mem_en[g] && mem_we[g]) mem[mem_addr[g][9:2]] <= mem_wdata[g];
      pv[0] <= mem_en[g] && !mem_we[g];
      pd[0] <= mem[mem_addr[g][9:2]];
      for (int i = 1; i < L; i++) begin
        pv[i] <= pv[i-1];
        pd[i] <= pd[i-1];
      end
    end
    assign mem_rdata[g] = pv[L-1] ? pd[L-1] : 32'hBAD0_BAD0;

    mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .RD_LAT(L)) u_dut (
      .clk_100M (clk),          .rst_n    (rst_n),
      .cpu_req  (cpu_req[g]),   .cpu_we   (cpu_we[g]),
      .cpu_addr (cpu_addr[g]),  .cpu_wdata(cpu_wdata[g]),
      .cpu_ack  (cpu_ack[g]),   .cpu_rdata(cpu_rdata[g]),
      .dbg_req  (dbg_req[g]),   .dbg_we   (dbg_we[g]),
      .dbg_addr (dbg_addr[g]),  .dbg_wdata(dbg_wdata[g]),
      .dbg_ack  (dbg_ack[g]),   .dbg_rdata(dbg_rdata[g]),
      .mem_en   (mem_en[g]),    .mem_we   (mem_we[g]),
      .mem_addr (mem_addr[g]),  .mem_wdata(mem_wdata[g]),
      .mem_rdata(mem_rdata[g]), .busy     (busy[g]),
      .owner    (owner[g])
    );
  end

  typedef struct {
    int            inst;
    bit            port;
    bit            we;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic [DW-1:0] rdata;
    int            ack_cyc;
  } sb_t;

  typedef struct {
    bit            port;
    bit            we;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic [DW-1:0] rdata;
  } vec_t;

  sb_t           sbq [$];
  int            errors = 0;
  int            checks = 0;
  int            cyc = 0;
  int            acks = 0;
  int            port_acks [NI][2];
  int            en_cyc [NI];
  logic [DW-1:0] shadow [NI][2];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Monitor: compare every memory strobe and every ack against the queue head.
  always @(negedge clk) begin
    for (int g = 0; g < NI; g++) begin
      if (mem_en[g]) begin
        en_cyc[g] = cyc;
        if (sbq.size() > 0 && sbq[0].inst == g) begin
          chk("mem_we", 64'(mem_we[g]), 64'(sbq[0].we));
          chk("mem_addr", 64'(mem_addr[g]), 64'(sbq[0].addr));
          if (sbq[0].we) chk("mem_wdata", 64'(mem_wdata[g]), 64'(sbq[0].wdata));
        end else chk("mem_en_spurious", 64'(1), 64'(0));
      end
      if (cpu_ack[g] || dbg_ack[g]) begin
        chk("ack_both", 64'(cpu_ack[g] && dbg_ack[g]), 64'(0));
        if (sbq.size() > 0 && sbq[0].inst == g) begin
          sb_t it;
          bit  p;
          it = sbq.pop_front();
          p  = dbg_ack[g];
          chk("ack_port", 64'(p), 64'(it.port));
          chk("owner", 64'(owner[g]), 64'(it.port));
          chk("busy_at_ack", 64'(busy[g]), 64'(1));
          if (it.ack_cyc >= 0) chk("ack_cycle", 64'(cyc), 64'(it.ack_cyc));
          chk("en_to_ack", 64'(cyc - en_cyc[g]), 64'(it.we ? 1 : lat_of(g) + 1));
          if (!it.we) shadow[g][p] = it.rdata;
          chk(p ? "dbg_rdata" : "cpu_rdata", 64'(p ? dbg_rdata[g] : cpu_rdata[g]),
              64'(shadow[g][p]));
          chk(p ? "cpu_rdata_hold" : "dbg_rdata_hold", 64'(p ? cpu_rdata[g] : dbg_rdata[g]),
              64'(shadow[g][!p]));
          port_acks[g][p]++;
        end else chk("ack_spurious", 64'(1), 64'(0));
        acks++;
      end
    end
  end

  task automatic drive(input int g, input bit port, input bit req, input bit we,
                       input logic [AW-1:0] addr, input logic [DW-1:0] wdata);
    if (port) begin
      dbg_req[g] = req; dbg_we[g] = we; dbg_addr[g] = addr; dbg_wdata[g] = wdata;
    end else begin
      cpu_req[g] = req; cpu_we[g] = we; cpu_addr[g] = addr; cpu_wdata[g] = wdata;
    end
  endtask

  // One complete transaction: raise req, queue expectation, hold until ack.
  task automatic do_req(input int g, input bit port, input bit we, input logic [AW-1:0] addr,
                        input logic [DW-1:0] wdata, input logic [DW-1:0] rdata);
    sb_t it;
    int  a0;
    int  n;
    @(posedge clk); #1;
    it = '{inst: g, port: port, we: we, addr: addr, wdata: wdata, rdata: rdata,
           ack_cyc: cyc + (we ? 2 : lat_of(g) + 2)};
    sbq.push_back(it);
    drive(g, port, 1'b1, we, addr, wdata);
    a0 = acks;
    n  = 0;
    while (acks == a0 && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
    if (acks == a0) begin
      chk("ack_timeout", 64'(0), 64'(1));
      sbq.delete();
    end
    drive(g, port, 1'b0, 1'b0, '0, '0);
  endtask

  task automatic do_reset();
    @(posedge clk); #2;
    rst_n = 1'b0;
    sbq.delete();
    for (int g = 0; g < NI; g++) begin
      shadow[g][0] = '0;
      shadow[g][1] = '0;
    end
    repeat (2) @(posedge clk);
    @(negedge clk); #1;
    rst_n = 1'b1;
  endtask

  task automatic chk_reset_outputs(input int g);
    chk("rst_mem_en", 64'(mem_en[g]), 64'(0));
    chk("rst_mem_we", 64'(mem_we[g]), 64'(0));
    chk("rst_mem_addr", 64'(mem_addr[g]), 64'(0));
    chk("rst_mem_wdata", 64'(mem_wdata[g]), 64'(0));
    chk("rst_acks", 64'({cpu_ack[g], dbg_ack[g]}), 64'(0));
    chk("rst_cpu_rdata", 64'(cpu_rdata[g]), 64'(0));
    chk("rst_dbg_rdata", 64'(dbg_rdata[g]), 64'(0));
    chk("rst_busy_owner", 64'({busy[g], owner[g]}), 64'(0));
  endtask

  // Both ports (or one) hold req for nper reads each; acks every RD_LAT+3 cycles.
  task automatic saturate(input bit use_dbg, input int nper);
    int t0;
    int total;
    total = use_dbg ? 2 * nper : nper;
    @(posedge clk); #1;
    t0 = cyc;
    for (int k = 0; k < total; k++) begin
      bit            p;
      logic [AW-1:0] a;
      p = use_dbg ? bit'(k % 2) : 1'b0;
      a = (p ? 32'h200 : 32'h300) + 32'((use_dbg ? k / 2 : k) * 4);
      sbq.push_back('{inst: 0, port: p, we: 1'b0, addr: a, wdata: '0,
                      rdata: {16'hC0DE, a[15:0]}, ack_cyc: t0 + 4 + 5 * k});
    end
    drive(0, 1'b0, 1'b1, 1'b0, 32'h300, '0);
    if (use_dbg) drive(0, 1'b1, 1'b1, 1'b0, 32'h200, '0);
    fork
      begin
        for (int k = 0; k < nper; k++) begin
          int c0, nc;
          c0 = port_acks[0][0];
          nc = 0;
          while (port_acks[0][0] == c0 && nc < 80) begin @(posedge clk); #1; nc++; end
          if (port_acks[0][0] == c0) chk("cpu_sat_timeout", 64'(0), 64'(1));
          cpu_addr[0] = cpu_addr[0] + 32'd4;
        end
        cpu_req[0] = 1'b0;
      end
      begin
        if (use_dbg) begin
          for (int k = 0; k < nper; k++) begin
            int d0, nd;
            d0 = port_acks[0][1];
            nd = 0;
            while (port_acks[0][1] == d0 && nd < 80) begin @(posedge clk); #1; nd++; end
            if (port_acks[0][1] == d0) chk("dbg_sat_timeout", 64'(0), 64'(1));
            dbg_addr[0] = dbg_addr[0] + 32'd4;
          end
          dbg_req[0] = 1'b0;
        end
      end
    join
    chk("sat_queue_drained", 64'(sbq.size()), 64'(0));
    sbq.delete();
  endtask

  initial begin
    vec_t tbl [9];
    int   a0;

    tbl = '{
      '{1'b0, 1'b0, 32'h040, 32'h0,         32'hDEAD_BEEF},
      '{1'b1, 1'b1, 32'h100, 32'h1234_5678, 32'h0},
      '{1'b0, 1'b0, 32'h100, 32'h0,         32'h1234_5678},
      '{1'b1, 1'b0, 32'h040, 32'h0,         32'hDEAD_BEEF},
      '{1'b0, 1'b1, 32'h3FC, 32'hA5A5_5A5A, 32'h0},
      '{1'b1, 1'b0, 32'h3FC, 32'h0,         32'hA5A5_5A5A},
      '{1'b0, 1'b0, 32'h080, 32'h0,         32'hC0DE_0080},
      '{1'b1, 1'b1, 32'h000, 32'hFFFF_FFFF, 32'h0},
      '{1'b1, 1'b0, 32'h000, 32'h0,         32'hFFFF_FFFF}
    };

    for (int g = 0; g < NI; g++) begin
      drive(g, 1'b0, 1'b0, 1'b0, '0, '0);
      drive(g, 1'b1, 1'b0, 1'b0, '0, '0);
      shadow[g][0] = '0;
      shadow[g][1] = '0;
      port_acks[g][0] = 0;
      port_acks[g][1] = 0;
      en_cyc[g] = 0;
    end
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk_reset_outputs(0);
    @(negedge clk); #1;
    rst_n = 1'b1;

    for (int i = 0; i < 9; i++)
      do_req(0, tbl[i].port, tbl[i].we, tbl[i].addr, tbl[i].wdata, tbl[i].rdata);
    chk("mem_written", 64'(g_dut[0].mem[64]), 64'(32'h1234_5678));

    // Reset in the middle of a read: outputs drop at once and no ack follows.
    @(posedge clk); #1;
    sbq.push_back('{inst: 0, port: 1'b0, we: 1'b0, addr: 32'h44, wdata: '0,
                    rdata: 32'hC0DE_0044, ack_cyc: -1});
    drive(0, 1'b0, 1'b1, 1'b0, 32'h44, '0);
    repeat (2) @(posedge clk);
    #2;
    chk("busy_in_wait", 64'(busy[0]), 64'(1));
    a0 = acks;
    rst_n = 1'b0;
    #1;
    chk_reset_outputs(0);
    sbq.delete();
    shadow[0][0] = '0;
    shadow[0][1] = '0;
    drive(0, 1'b0, 1'b0, 1'b0, '0, '0);
    repeat (4) @(posedge clk);
    chk("no_ack_after_abort", 64'(acks), 64'(a0));
    @(negedge clk); #1;
    rst_n = 1'b1;
    do_req(0, 1'b0, 1'b0, 32'h44, '0, 32'hC0DE_0044);

    do_reset();
    saturate(1'b1, 4);
    saturate(1'b0, 3);

    do_req(1, 1'b0, 1'b0, 32'h040, '0, 32'hDEAD_BEEF);
    do_req(1, 1'b1, 1'b0, 32'h084, '0, 32'hC0DE_0084);
    do_req(2, 1'b0, 1'b0, 32'h040, '0, 32'hDEAD_BEEF);
    do_req(2, 1'b1, 1'b1, 32'h084, 32'h0BAD_F00D, '0);
    do_req(2, 1'b0, 1'b0, 32'h084, '0, 32'h0BAD_F00D);

    repeat (5) @(posedge clk);
    chk("final_queue_empty", 64'(sbq.size()), 64'(0));
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1);
  end

endmodule
